seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Multi-cycle, parametrised radix-2 restoring divider. It is the sequential successor to the single-cycle combinational unsigned divider in the execute stage. It adds signed/unsigned mode, a start/busy/done handshake, a cancel input for pipeline flush, and defined divide-by-zero results. The CPU stall logic uses busy to hold the pipeline while the result for DIV/DIVU is being formed.

Parameters:
WIDTH, 32, operand/result width in bits (minimum 2).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  launch request; accepted only when busy=0
is_signed  input  1  1 = two's-complement operands (DIV), 0 = unsigned (DIVU); sampled with start
cancel  input  1  abort in-flight operation (pipeline flush)
dividend  input  WIDTH  dividend; sampled with start
divisor  input  WIDTH  divisor; sampled with start
busy  output  1  operation in flight; new start ignored
done  output  1  one-cycle pulse; q/r valid
q  output  WIDTH  quotient, registered, held until next done
r  output  WIDTH  remainder, registered, held until next done
div_zero  output  1  divisor was 0 for the result currently on q/r

Behaviour:
- Reset: clk and async active-low rst_n as decided. rst_n=0 forces IDLE, and busy=0, done=0, q=0, r=0, div_zero=0, counter=0, immediately and independent of clk. Reset mid-operation discards the operation; no done follows.
- FSM: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 at edge: latch magnitudes |dividend| and |divisor| (signed mode), or the raw operands (unsigned mode).
  - Latch sign flags: qneg = signs differ; rneg = dividend sign. Latch zero flag.
  - Clear the partial remainder (WIDTH+1 bits). Load counter = WIDTH. Go to RUN; busy=1 from the next cycle.
- RUN, one step per cycle:
  - Shift {rem, quo} left 1; trial = rem - divisor_mag.
  - If trial is non-negative: rem = trial, quotient LSB = 1; otherwise quotient LSB = 0.
  - Decrement counter; at counter==1, go to FIX.
- FIX:
  - Apply sign correction: q = qneg ? -quo : quo; r = rneg ? -rem : rem.
  - Register q, r, div_zero. Go to IDLE.
  - On that edge: busy drops to 0 and done=1 for exactly one cycle.
- Latency: start sampled at edge 0 -> done high during the cycle after edge WIDTH+1 (34 cycles for WIDTH=32). Latency is constant for all operands, including divisor=0.
- Divide by zero: q = all ones, r = dividend (original signed value), div_zero=1. This follows naturally from the algorithm on magnitudes and is then forced in FIX; no trap is raised.
- Signed overflow (MIN / -1): q = MIN (0x80000000), r = 0; no flag.
- Remainder sign equals dividend sign; quotient truncates toward zero.
- start while busy=1: ignored, no effect on in-flight operands.
- start in the same cycle as done: accepted (FSM is in IDLE).
- cancel=1 while busy: returns to IDLE next edge, busy=0, no done, q/r/div_zero keep old values.
  - cancel has priority over FIX completion.
  - cancel together with start in IDLE: start wins (cancel only acts on an in-flight operation).
- Width rules: the internal remainder is WIDTH+1 bits to hold the trial subtraction sign. Negation is two's complement modulo 2^WIDTH.

Optional Feature:
SEQ_DIVIDER_SIGNED_EN.
- Defined: is_signed is honoured as above.
- Undefined: is_signed is ignored and treated as 0, the magnitude/negation logic is removed, and the unit is unsigned only. Latency is unchanged (FIX still occupies one cycle) so stall timing is identical.

Decomposition:
- Package div_pkg: FSM state enum (S_IDLE, S_RUN, S_FIX), DIV_WIDTH_DEFAULT=32, and a helper function abs_val.
- One natural sub-module, div_step: a combinational single iteration (shift, trial subtract, select), instantiated once in seq_divider.

Test Plan:
- Unsigned 100 / 7, start at cycle 0 -> done at cycle 34, q=14, r=2, div_zero=0, busy high for cycles 1-33.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2) -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 / -2 -> q=0xFFFFFFFD, r=1.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. Unsigned 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0.
- Divide by zero 5 / 0 (both modes) -> q=0xFFFFFFFF, r=5, div_zero=1, same 34-cycle latency.
- Handshake edges:
  - Second start at cycle 10 with different operands is ignored; the first result is returned.
  - cancel at cycle 20 -> busy=0 at 21, no done, q/r unchanged.
  - Back-to-back start on the done cycle is accepted.
- rst_n pulsed low asynchronously at cycle 15 mid-operation -> all outputs 0 immediately, no done afterwards; a new start after release completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//
// Contents:
//   div_state_e        FSM state encoding (S_IDLE, S_RUN, S_FIX)
//   DIV_WIDTH_DEFAULT  default operand/result width
//   DIV_MAX_W          width of the abs_val helper; dividers up to DIV_MAX_W-1 bits
//   abs_val            two's-complement negation when 'neg' is set, else pass-through
//
// Optional feature macro used by the importing files: SEQ_DIVIDER_SIGNED_EN.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam int DIV_MAX_W         = 64;

    // Conditional negation on a fixed wide word. Callers zero-extend their
    // operand and keep the low bits; negation modulo 2^DIV_MAX_W truncated to
    // WIDTH bits equals negation modulo 2^WIDTH.
    function automatic logic [DIV_MAX_W-1:0] abs_val(input logic [DIV_MAX_W-1:0] v,
                                                     input logic                 neg);
        return neg ? (~v + DIV_MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
//
// Ports:
//   rem_in   [WIDTH-1:0]  partial remainder (always < divisor, so WIDTH bits suffice)
//   quo_in   [WIDTH-1:0]  dividend/quotient shift register
//   dvs      [WIDTH-1:0]  divisor magnitude
//   rem_out  [WIDTH:0]    next partial remainder
//   quo_out  [WIDTH-1:0]  next quotient shift register (new bit in LSB)
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        // Shift {rem, quo} left by one; the MSB of quo moves into rem.
        rem_sh = {rem_in, quo_in[WIDTH-1]};
        // WIDTH+1 bit subtraction: bit WIDTH is the borrow/sign of the trial.
        trial  = rem_sh - {1'b0, dvs};
        if (!trial[WIDTH]) begin
            rem_out = trial;
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = rem_sh;
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with start/busy/done
// handshake, cancel for pipeline flush and defined divide-by-zero results.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        launch request, accepted only when busy=0
//   is_signed    1 = two's-complement operands, sampled with start
//   cancel       abort the in-flight operation (no done follows)
//   dividend     dividend, sampled with start
//   divisor      divisor, sampled with start
//   busy         operation in flight (RUN or FIX)
//   done         one-cycle pulse, q/r/div_zero updated
//   q, r         registered quotient/remainder, held until the next done
//   div_zero     divisor was zero for the result on q/r
//
// Handshake: start is taken on a rising edge where the FSM is idle (busy=0);
// busy is high from the following cycle until the edge that raises done.
// done and busy are never high together, so start may be asserted in the
// done cycle and is accepted. start while busy is dropped silently.
//
// Configuration macro: SEQ_DIVIDER_SIGNED_EN. When undefined, is_signed is
// ignored and the unit divides unsigned only; latency is identical.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic             zero_flag;

    // Operand magnitudes at start and sign-corrected results in FIX.
    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    // The top remainder bit is always zero between iterations; it only
    // carries the trial sign inside div_step.
    logic unused_rem_msb;
    assign unused_rem_msb = rem[WIDTH];

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic qneg;
    logic rneg;
    logic dvd_neg;
    logic dvs_neg;
    logic [DIV_MAX_W-WIDTH-1:0] unused_dvd_hi;
    logic [DIV_MAX_W-WIDTH-1:0] unused_dvs_hi;
    logic [DIV_MAX_W-WIDTH-1:0] unused_q_hi;
    logic [DIV_MAX_W-WIDTH-1:0] unused_r_hi;

    always_comb begin
        dvd_neg       = is_signed & dividend[WIDTH-1];
        dvs_neg       = is_signed & divisor[WIDTH-1];
        unused_dvd_hi = '0;
        unused_dvs_hi = '0;
        unused_q_hi   = '0;
        unused_r_hi   = '0;
        dvd_mag_in    = '0;
        dvs_mag_in    = '0;
        q_fix         = '0;
        r_fix         = '0;
        {unused_dvd_hi, dvd_mag_in} = abs_val(DIV_MAX_W'(dividend), dvd_neg);
        {unused_dvs_hi, dvs_mag_in} = abs_val(DIV_MAX_W'(divisor), dvs_neg);
        {unused_q_hi, q_fix}        = abs_val(DIV_MAX_W'(quo), qneg);
        {unused_r_hi, r_fix}        = abs_val(DIV_MAX_W'(rem[WIDTH-1:0]), rneg);
        // Divide by zero: the magnitude loop leaves quo all ones, but a sign
        // correction could flip it, so force it here. r_fix already equals
        // the original dividend (magnitude re-signed).
        if (zero_flag) begin
            q_fix = '1;
        end
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = is_signed;

    always_comb begin
        dvd_mag_in = dividend;
        dvs_mag_in = divisor;
        q_fix      = zero_flag ? '1 : quo;
        r_fix      = rem[WIDTH-1:0];
    end
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem[WIDTH-1:0]),
        .quo_in  (quo),
        .dvs     (dvs_mag),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs_mag   <= '0;
            zero_flag <= 1'b0;
            done      <= 1'b0;
            q         <= '0;
            r         <= '0;
            div_zero  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg      <= 1'b0;
            rneg      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // cancel is ignored here: it only acts on an in-flight op.
                    if (start) begin
                        quo       <= dvd_mag_in;
                        dvs_mag   <= dvs_mag_in;
                        zero_flag <= (divisor == '0);
                        rem       <= '0;
                        cnt       <= CNT_W'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
                        qneg      <= dvd_neg ^ dvs_neg;
                        rneg      <= dvd_neg;
`endif
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        rem <= step_rem;
                        quo <= step_quo;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    // cancel wins over completion: outputs keep old values.
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        q        <= q_fix;
                        r        <= r_fix;
                        div_zero <= zero_flag;
                        done     <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider (WIDTH=32). Expected results are hand-computed
// constants; the signed vectors carry two expected sets selected by
// SEQ_DIVIDER_SIGNED_EN (unsigned-only build treats them as unsigned).
module tb_seq_divider;

    localparam int W   = 32;
    localparam int LAT = W + 1;  // start edge to the edge that raises done

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic         cancel;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .cancel    (cancel),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r),
        .div_zero  (div_zero)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [2*W:0] exp_q[$];   // {div_zero, q, r}
    int           lat_q[$];   // edge count at which start was sampled
    int           checks   = 0;
    int           failures = 0;

    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got done=1 q=%h r=%h, required no done", q, r);
            end else begin
                logic [2*W:0] e;
                int           s;
                e = exp_q.pop_front();
                s = lat_q.pop_front();
                if ({div_zero, q, r} !== e) begin
                    failures++;
                    $display("FAIL result: got z=%0b q=%h r=%h, required z=%0b q=%h r=%h",
                             div_zero, q, r, e[2*W], e[2*W-1:W], e[W-1:0]);
                end
                checks++;
                if (cyc - s != LAT) begin
                    failures++;
                    $display("FAIL latency: got %0d, required %0d", cyc - s, LAT);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called right after a negedge; drives one start pulse and returns at the
    // negedge after the sampling edge.
    task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit push, input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic ez);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        if (push) begin
            exp_q.push_back({ez, eq, er});
            lat_q.push_back(cyc + 1);
        end
        @(negedge clk);
        start     = 1'b0;
        dividend  = $urandom_range(0, 1000);
        divisor   = $urandom_range(0, 1000);
        is_signed = $urandom_range(0, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL timeout_%s: busy=%0b pending=%0d, required idle within 100 cycles",
                     name, busy, exp_q.size());
        end
    endtask

    task automatic check1(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
    } vec_t;

    vec_t vecs[10];

    initial begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs[0] = '{1'b1, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[1] = '{1'b1, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1,         1'b0};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1'b0};
        vecs[3] = '{1'b1, 32'hFFFF_FF9C, 32'h7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
`else
        vecs[0] = '{1'b1, 32'hFFFF_FFF9, 32'h2,         32'h7FFF_FFFC, 32'h1,         1'b0};
        vecs[1] = '{1'b1, 32'h7,         32'hFFFF_FFFE, 32'h0,         32'h7,         1'b0};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
        vecs[3] = '{1'b1, 32'hFFFF_FF9C, 32'h7,         32'h2492_4916, 32'h2,         1'b0};
`endif
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[5] = '{1'b0, 32'h5,         32'h0,         32'hFFFF_FFFF, 32'h5,         1'b1};
        vecs[6] = '{1'b1, 32'h5,         32'h0,         32'hFFFF_FFFF, 32'h5,         1'b1};
        vecs[7] = '{1'b1, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1};
        vecs[8] = '{1'b0, 32'd1000,      32'd1000,      32'h1,         32'h0,         1'b0};
        vecs[9] = '{1'b0, 32'd3,         32'd10,        32'h0,         32'h3,         1'b0};
    end

    // ---------------- main sequence ----------------
    initial begin
        int busy_cnt;
        int n;

        rst_n     = 1'b0;
        start     = 1'b0;
        cancel    = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check1("reset_busy", W'(busy), '0);
        check1("reset_done", W'(done), '0);
        check1("reset_q", q, '0);
        check1("reset_r", r, '0);
        check1("reset_div_zero", W'(div_zero), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned 100 / 7 with busy-window measurement
        start_op(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
        busy_cnt = 0;
        n        = 0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check1("busy_cycles", W'(busy_cnt), W'(LAT));
        check1("busy_at_done", W'(busy), '0);
        wait_idle("u100_7");

        // Directed vectors
        foreach (vecs[i]) begin
            start_op(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b1, vecs[i].eq, vecs[i].er, vecs[i].ez);
            wait_idle("vec");
        end

        // start while busy is ignored: 200/9 result must come back
        start_op(1'b0, 32'd200, 32'd9, 1'b1, 32'd22, 32'd2, 1'b0);
        repeat (9) @(negedge clk);
        start_op(1'b0, 32'd99, 32'd3, 1'b0, '0, '0, 1'b0);
        wait_idle("ignored_start");

        // cancel mid-operation: busy drops next edge, no done, outputs held
        start_op(1'b0, 32'd77, 32'd7, 1'b0, '0, '0, 1'b0);
        repeat (19) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check1("cancel_busy", W'(busy), '0);
        repeat (40) @(negedge clk);
        check1("cancel_q_held", q, 32'd22);
        check1("cancel_r_held", r, 32'd2);

        // back-to-back: start on the done cycle is accepted
        start_op(1'b0, 32'd1000, 32'd7, 1'b1, 32'd142, 32'd6, 1'b0);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        start_op(1'b0, 32'd45, 32'd6, 1'b1, 32'd7, 32'd3, 1'b0);
        wait_idle("back_to_back");

        // asynchronous reset mid-operation
        start_op(1'b0, 32'd500, 32'd3, 1'b0, '0, '0, 1'b0);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check1("arst_busy", W'(busy), '0);
        check1("arst_q", q, '0);
        check1("arst_r", r, '0);
        check1("arst_div_zero", W'(div_zero), '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        start_op(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
        wait_idle("after_reset");

        repeat (3) @(negedge clk);
        check1("queue_empty", W'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
